swap_pair_driver: RTL and testbench

Initiator-side companion to `register_swap`: accepts a byte stream over a valid/ready handshake and pairs consecutive bytes as first→`reg1`, second→`reg2`. It drives the pair into the swap unit and waits a fixed latency. It then captures `reg1_out`/`reg2_out` and returns them as a two-byte output stream. It sits between a byte source (UART/test sequencer) and the `register_swap` instance.

---
 rtl/swap_pair_driver.sv | 158 +++++++++++++++
 tb/tb_swap_pair_driver.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swap_pair_driver.sv
// swap_pair_driver: pairs an incoming byte stream into reg1/reg2 for a register_swap unit.
// It waits SWAP_LATENCY edges, captures the swapped results and streams them back out
// as two bytes.
// Optional feature: define SWAP_CHECK_EN to build the swap-mismatch comparator behind `err`.
module swap_pair_driver #(
  parameter int unsigned SWAP_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] reg1,
  output logic [7:0] reg2,
  input  logic [7:0] reg1_out,
  input  logic [7:0] reg2_out,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pair_cnt,
  output logic       err
);

  localparam int unsigned CntW = 4;

  typedef enum logic [2:0] {
    StIdleA,
    StWaitB,
    StLaunch,
    StSend1,
    StSend2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        reg1_q, reg1_d;
  logic [7:0]        reg2_q, reg2_d;
  logic [7:0]        cap2_q, cap2_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [7:0]        pair_cnt_q, pair_cnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept_in;
  logic              capture;

  // Handshake flags are pure decodes of the registered state.
  assign in_ready  = (state_q == StIdleA) || (state_q == StWaitB);
  assign out_valid = (state_q == StSend1) || (state_q == StSend2);
  assign accept_in = in_valid && in_ready;
  assign capture   = (state_q == StLaunch) && (cnt_q == '0);

  assign reg1     = reg1_q;
  assign reg2     = reg2_q;
  assign out_data = out_data_q;
  assign pair_cnt = pair_cnt_q;

  // Next-state and datapath updates for the pair sequencer.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    reg1_d     = reg1_q;
    reg2_d     = reg2_q;
    cap2_d     = cap2_q;
    out_data_d = out_data_q;
    pair_cnt_d = pair_cnt_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdleA: begin
        if (accept_in) begin
          hold_d  = in_data;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (accept_in) begin
          reg1_d  = hold_q;
          reg2_d  = in_data;
          cnt_d   = CntW'(SWAP_LATENCY);
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        if (capture) begin
          // out_data doubles as the first capture register (cap1).
          out_data_d = reg1_out;
          cap2_d     = reg2_out;
          state_d    = StSend1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSend1: begin
        if (out_ready) begin
          out_data_d = cap2_q;
          state_d    = StSend2;
        end
      end
      StSend2: begin
        if (out_ready) begin
          pair_cnt_d = pair_cnt_q + 8'd1;
          state_d    = StIdleA;
        end
      end
      default: state_d = StIdleA;
    endcase
  end

  // State and datapath registers; reset drops any partial or in-flight pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdleA;
      hold_q     <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      cap2_q     <= '0;
      out_data_q <= '0;
      pair_cnt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      cap2_q     <= cap2_d;
      out_data_q <= out_data_d;
      pair_cnt_q <= pair_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef SWAP_CHECK_EN
  logic err_q, err_d;
  logic mismatch;

  assign mismatch = (reg1_out != reg2_q) || (reg2_out != reg1_q);

  // Sticky flag: set on a capture whose results are not the swapped launch values.
  always_comb begin
    err_d = err_q;
    if (capture && mismatch) begin
      err_d = 1'b1;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_swap_pair_driver.sv
// Directed bench for swap_pair_driver with a one-stage register_swap model.
module tb_swap_pair_driver;

  localparam int unsigned L = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] reg1, reg2;
  logic [7:0] reg1_out = 8'h00;
  logic [7:0] reg2_out = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] pair_cnt;
  logic       err;
  bit         fault = 1'b0;

  int total = 0;
  int passed = 0;

  swap_pair_driver #(.SWAP_LATENCY(L)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .reg1     (reg1),
    .reg2     (reg2),
    .reg1_out (reg1_out),
    .reg2_out (reg2_out),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pair_cnt (pair_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Swap unit model: one register stage; faulty mode passes values straight through.
  always @(posedge clk) begin
    reg1_out <= fault ? reg1 : reg2;
    reg2_out <= fault ? reg2 : reg1;
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        b = out_data;
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic wait_out_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [36:0] got;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = {in_ready, out_valid, err, reg1, reg2, out_data, pair_cnt, 2'b00};
    total++;
    if (got !== {1'b1, 1'b0, 1'b0, 34'h0})
      $display("FAIL reset_values: got %h want %h", got, {1'b1, 36'h0});
    else passed++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    got = {in_ready, out_valid, err, reg1, reg2, out_data, pair_cnt, 2'b00};
    total++;
    if (got !== {1'b1, 1'b0, 1'b0, 34'h0})
      $display("FAIL idle_after_reset: got %h want %h", got, {1'b1, 36'h0});
    else passed++;
  endtask

  task automatic test_single_pair();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h12;
    @(negedge clk);
    in_data = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({reg1, reg2} !== 16'h1234)
      $display("FAIL single_regs: got %h want 1234", {reg1, reg2});
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_early_valid_n: got %b want 0", out_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_early_valid_n1: got %b want 0", out_valid);
    else passed++;
    @(negedge clk);
    total++;
    if ({out_valid, out_data, in_ready} !== {1'b1, 8'h34, 1'b0})
      $display("FAIL single_first_byte: got %b/%h/%b want 1/34/0", out_valid, out_data, in_ready);
    else passed++;
    @(negedge clk);
    total++;
    if ({out_valid, out_data} !== {1'b1, 8'h12})
      $display("FAIL single_second_byte: got %b/%h want 1/12", out_valid, out_data);
    else passed++;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, pair_cnt} !== {1'b0, 1'b1, 8'd1})
      $display("FAIL single_done: got %b/%b/%0d want 0/1/1", out_valid, in_ready, pair_cnt);
    else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok1, ok2, okw;
    logic [7:0] b1, b2;
    out_ready = 1'b0;
    send_byte(8'h12, ok1);
    send_byte(8'h34, ok2);
    wait_out_valid(okw);
    total++;
    if (!(ok1 && ok2 && okw)) $display("FAIL bp_handshake: got %b%b%b want 111", ok1, ok2, okw);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 8'h34, 1'b0})
        $display("FAIL bp_stall_%0d: got %b/%h/%b want 1/34/0", i, out_valid, out_data, in_ready);
      else passed++;
      @(negedge clk);
    end
    recv_byte(b1, ok1);
    recv_byte(b2, ok2);
    total++;
    if (!(ok1 && ok2) || {b1, b2} !== 16'h3412)
      $display("FAIL bp_release: got %h ok %b%b want 3412", {b1, b2}, ok1, ok2);
    else passed++;
    total++;
    if (pair_cnt !== 8'd2) $display("FAIL bp_pair_cnt: got %0d want 2", pair_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_pair();
    bit ok1, ok2;
    logic [7:0] b1, b2;
    send_byte(8'hAA, ok1);
    total++;
    if (!ok1 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL mid_first_byte: got ok %b rdy %b vld %b want 1/1/0", ok1, in_ready, out_valid);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({pair_cnt, reg1, reg2, in_ready} !== {24'h0, 1'b1})
      $display("FAIL mid_async_reset: got %h/%h/%h/%b want 00/00/00/1", pair_cnt, reg1, reg2, in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h01, ok1);
    send_byte(8'h02, ok2);
    total++;
    if (!(ok1 && ok2) || {reg1, reg2} !== 16'h0102)
      $display("FAIL mid_regs: got %h want 0102", {reg1, reg2});
    else passed++;
    recv_byte(b1, ok1);
    recv_byte(b2, ok2);
    total++;
    if (!(ok1 && ok2) || {b1, b2} !== 16'h0201)
      $display("FAIL mid_output: got %h ok %b%b want 0201", {b1, b2}, ok1, ok2);
    else passed++;
    // Unsent pair must be dropped without counting.
    send_byte(8'h77, ok1);
    send_byte(8'h88, ok2);
    wait_out_valid(ok1);
    rst_n = 1'b0;
    #1;
    total++;
    if (!ok1 || {out_valid, out_data, pair_cnt} !== 17'h0)
      $display("FAIL drop_unsent: got %b/%h/%0d want 0/00/0", out_valid, out_data, pair_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3, ok4;
    logic [7:0] a, b, x, y;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      b = a ^ 8'hA5;
      send_byte(a, ok1);
      send_byte(b, ok2);
      recv_byte(x, ok3);
      recv_byte(y, ok4);
      total++;
      if (!(ok1 && ok2 && ok3 && ok4) || x !== b || y !== a) begin
        bad++;
        if (bad <= 8) $display("FAIL b2b_pair_%0d: got %h%h want %h%h", i, x, y, b, a);
      end else passed++;
      if (i == 254) begin
        total++;
        if (pair_cnt !== 8'd255) $display("FAIL b2b_cnt_255: got %0d want 255", pair_cnt);
        else passed++;
      end
    end
    total++;
    if (pair_cnt !== 8'd0) $display("FAIL b2b_cnt_wrap: got %0d want 0", pair_cnt);
    else passed++;
  endtask

  task automatic test_swap_check();
    bit ok1, ok2;
    logic [7:0] b1, b2;
    logic exp_err;
`ifdef SWAP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    fault = 1'b1;
    do_reset();
    send_byte(8'h55, ok1);
    send_byte(8'h66, ok2);
    total++;
    if (err !== 1'b0) $display("FAIL chk_err_before_capture: got %b want 0", err);
    else passed++;
    wait_out_valid(ok1);
    total++;
    if (!ok1 || err !== exp_err) $display("FAIL chk_err_at_capture: got %b want %b", err, exp_err);
    else passed++;
    recv_byte(b1, ok1);
    recv_byte(b2, ok2);
    total++;
    if (!(ok1 && ok2) || {b1, b2} !== 16'h5566)
      $display("FAIL chk_output: got %h want 5566", {b1, b2});
    else passed++;
    fault = 1'b0;
    send_byte(8'h0F, ok1);
    send_byte(8'hF0, ok2);
    recv_byte(b1, ok1);
    recv_byte(b2, ok2);
    total++;
    if ({b1, b2} !== 16'hF00F || err !== exp_err)
      $display("FAIL chk_err_sticky: got %h err %b want F00F err %b", {b1, b2}, err, exp_err);
    else passed++;
    do_reset();
    total++;
    if (err !== 1'b0) $display("FAIL chk_err_cleared: got %b want 0", err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_backpressure();
    test_reset_mid_pair();
    test_back_to_back();
    test_swap_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
